// File: rtl/demux2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux2_stream : 1-to-2 registered stream demux into two independent FIFOs |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module demux2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_select,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         a_data,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [WIDTH-1:0]         b_data,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [1:0]             w_push;
  logic [1:0]             w_pop;
  logic [1:0]             w_full;
  logic [1:0]             w_valid;
  logic [WIDTH-1:0]       w_head  [2];
  logic [c_cnt_w-1:0]     w_count [2];

  // Full-FIFO push is refused even if that FIFO pops this cycle (no pass-through).
  assign in_ready  = ~w_full[in_select];
  assign w_push[0] = in_valid & in_ready & ~in_select;
  assign w_push[1] = in_valid & in_ready &  in_select;
  assign w_pop[0]  = w_valid[0] & a_ready;
  assign w_pop[1]  = w_valid[1] & b_ready;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_fifo
      logic [c_ptr_w-1:0] r_wr_ptr;
      logic [c_ptr_w-1:0] r_rd_ptr;
      logic [c_cnt_w-1:0] r_count;
      logic [WIDTH-1:0]   r_mem [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
          end
        end else begin
          if (w_push[g]) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
          end
          if (w_pop[g]) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          case ({w_push[g], w_pop[g]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end

      assign w_full[g]  = (r_count == c_cnt_w'(DEPTH));
      assign w_valid[g] = (r_count != '0);
      assign w_head[g]  = r_mem[r_rd_ptr];
      assign w_count[g] = r_count;
    end
  endgenerate

  assign a_valid = w_valid[0];
  assign a_data  = w_head[0];
  assign a_count = w_count[0];
  assign b_valid = w_valid[1];
  assign b_data  = w_head[1];
  assign b_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// Testbench for demux2_stream: directed vector table, reset/ordering sequences, random scoreboard.
module tb_demux2_stream;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_select;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic [1:0]       a_count, b_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] a_seen[$];
  logic [31:0] b_seen[$];

  typedef struct {
    logic        iv;
    logic        sel;
    logic [31:0] d;
    logic        ar;
    logic        br;
    logic        rdy;
    logic        av;
    logic [31:0] ad;
    logic [1:0]  ac;
    logic        bv;
    logic [31:0] bd;
    logic [1:0]  bc;
  } vec_t;

  vec_t vq[$];

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_count(a_count),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, sel, input logic [31:0] d, input logic ar, br, rdy,
                     input logic av, input logic [31:0] ad, input logic [1:0] ac,
                     input logic bv, input logic [31:0] bd, input logic [1:0] bc);
    vec_t v;
    v.iv = iv; v.sel = sel; v.d = d; v.ar = ar; v.br = br; v.rdy = rdy;
    v.av = av; v.ad = ad; v.ac = ac; v.bv = bv; v.bd = bd; v.bc = bc;
    vq.push_back(v);
  endtask

  // One cycle against the queue model: check pre-edge state, then apply the edge to the model.
  task automatic step(input logic iv, sel, input logic [31:0] d, input logic ar, br);
    int  occ;
    logic pa, pb, acc;
    @(negedge clk);
    in_valid = iv; in_select = sel; in_data = d; a_ready = ar; b_ready = br;
    #1;
    occ = sel ? qb.size() : qa.size();
    chk("sb_in_ready", {31'b0, in_ready}, {31'b0, occ < DEPTH});
    chk("sb_a_valid", {31'b0, a_valid}, {31'b0, qa.size() != 0});
    chk("sb_b_valid", {31'b0, b_valid}, {31'b0, qb.size() != 0});
    chk("sb_a_count", {30'b0, a_count}, qa.size());
    chk("sb_b_count", {30'b0, b_count}, qb.size());
    if (qa.size() != 0) chk("sb_a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("sb_b_data", b_data, qb[0]);
    chk("sb_count_bound", {31'b0, (a_count > 2'(DEPTH)) || (b_count > 2'(DEPTH))}, 32'd0);
    pa  = ar && (qa.size() != 0);
    pb  = br && (qb.size() != 0);
    acc = iv && (occ < DEPTH);
    if (pa) a_seen.push_back(a_data);
    if (pb) b_seen.push_back(b_data);
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (sel) qb.push_back(d);
      else     qa.push_back(d);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_select = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;

    //     iv sel data          ar br rdy av a_data        ac bv b_data        bc
    add(1, 0, 32'h11111111, 0, 0, 1, 1, 32'h11111111, 1, 0, 32'h0,        0);
    add(1, 1, 32'h22222222, 0, 0, 1, 1, 32'h11111111, 1, 1, 32'h22222222, 1);
    add(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0);
    add(1, 0, 32'h000000A0, 0, 0, 1, 1, 32'h000000A0, 1, 0, 32'h0,        0);
    add(1, 0, 32'h000000A1, 0, 0, 1, 1, 32'h000000A0, 2, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 0, 0, 1, 32'h000000A0, 2, 0, 32'h0,        0);
    add(1, 1, 32'h000000B0, 0, 0, 1, 1, 32'h000000A0, 2, 1, 32'h000000B0, 1);
    add(1, 0, 32'h000000A2, 1, 0, 0, 1, 32'h000000A1, 1, 1, 32'h000000B0, 1);
    add(1, 0, 32'h000000A2, 0, 0, 1, 1, 32'h000000A1, 2, 1, 32'h000000B0, 1);
    add(0, 0, 32'h0,        1, 1, 0, 1, 32'h000000A2, 1, 0, 32'h0,        0);
    add(0, 1, 32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0);
    add(1, 1, 32'h33333333, 0, 1, 1, 0, 32'h0,        0, 1, 32'h33333333, 1);
    add(0, 1, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", {31'b0, a_valid}, 32'd0);
    chk("rst_b_valid", {31'b0, b_valid}, 32'd0);
    chk("rst_a_count", {30'b0, a_count}, 32'd0);
    chk("rst_b_count", {30'b0, b_count}, 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      in_valid = vq[i].iv; in_select = vq[i].sel; in_data = vq[i].d;
      a_ready = vq[i].ar; b_ready = vq[i].br;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vq[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_valid", i), {31'b0, a_valid}, {31'b0, vq[i].av});
      chk($sformatf("v%0d_a_count", i), {30'b0, a_count}, {30'b0, vq[i].ac});
      chk($sformatf("v%0d_b_valid", i), {31'b0, b_valid}, {31'b0, vq[i].bv});
      chk($sformatf("v%0d_b_count", i), {30'b0, b_count}, {30'b0, vq[i].bc});
      if (vq[i].av) chk($sformatf("v%0d_a_data", i), a_data, vq[i].ad);
      if (vq[i].bv) chk($sformatf("v%0d_b_data", i), b_data, vq[i].bd);
    end

    // Asynchronous reset mid-stream with A holding two words.
    step(1, 0, 32'hAAAA0001, 0, 0);
    step(1, 0, 32'hAAAA0002, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    #1;
    chk("pre_rst_a_count", {30'b0, a_count}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", {31'b0, a_valid}, 32'd0);
    chk("arst_b_valid", {31'b0, b_valid}, 32'd0);
    chk("arst_a_count", {30'b0, a_count}, 32'd0);
    chk("arst_b_count", {30'b0, b_count}, 32'd0);
    chk("arst_a_data", a_data, 32'd0);
    chk("arst_b_data", b_data, 32'd0);
    qa.delete(); qb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Interleaved pushes with consumers draining one word every other cycle.
    a_seen.delete(); b_seen.delete();
    step(1, 0, 32'hA1, 0, 0);
    step(1, 1, 32'hB1, 1, 1);
    step(1, 0, 32'hA2, 0, 0);
    step(1, 1, 32'hB2, 1, 1);
    step(1, 0, 32'hA3, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, i[0] == 1'b0, i[0] == 1'b0);
    chk("ord_a_len", a_seen.size(), 32'd3);
    chk("ord_b_len", b_seen.size(), 32'd2);
    if (a_seen.size() == 3) begin
      chk("ord_a0", a_seen[0], 32'hA1);
      chk("ord_a1", a_seen[1], 32'hA2);
      chk("ord_a2", a_seen[2], 32'hA3);
    end
    if (b_seen.size() == 2) begin
      chk("ord_b0", b_seen[0], 32'hB1);
      chk("ord_b1", b_seen[1], 32'hB2);
    end

    // Random traffic against the two-queue model.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
